// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel 3x3 window generator.
package sobel_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int N_TAPS     = 9;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DRAIN} state_t;

  // Row-major tap positions; TAP_BR is always the newest pixel.
  localparam int TAP_TL = 0;
  localparam int TAP_TC = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_MC = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BC = 7;
  localparam int TAP_BR = 8;

endpackage

// File: rtl/sobel_line_buf.sv
// One-line pixel store: combinational read and synchronous write at the same address,
// so a read in the write cycle returns the old contents. Not reset; priming refills it.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-stream 3x3 window generator: one registered window per accepted interior pixel, 1 clk latency,
// single output stage (input stalls while a window is held). Centre coordinates added with SOBEL_WIN_COORD_EN.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                       clk_i_s,
  input  logic                       rst_i_s,
  input  logic [DATA_W-1:0]          pix_i,
  input  logic                       pix_valid_i,
  output logic                       pix_ready_o,
  output logic [DATA_W-1:0]          win_o_0,
  output logic [DATA_W-1:0]          win_o_1,
  output logic [DATA_W-1:0]          win_o_2,
  output logic [DATA_W-1:0]          win_o_3,
  output logic [DATA_W-1:0]          win_o_4,
  output logic [DATA_W-1:0]          win_o_5,
  output logic [DATA_W-1:0]          win_o_6,
  output logic [DATA_W-1:0]          win_o_7,
  output logic [DATA_W-1:0]          win_o_8,
  output logic                       win_valid_o,
  input  logic                       win_ready_i,
  output logic                       frame_done_o
`ifdef SOBEL_WIN_COORD_EN
  ,
  output logic [$clog2(IMG_H)-1:0]   win_row_o,
  output logic [$clog2(IMG_W)-1:0]   win_col_o
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t            state, state_nx;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              accept, emit, col_last, row_last, win_hit;
  logic [DATA_W-1:0] lb0_q, lb1_q;
  // Two older columns of the neighbourhood (index 0 = top); the third is the column arriving now.
  logic [DATA_W-1:0] col_a [3];
  logic [DATA_W-1:0] col_b [3];
  logic [DATA_W-1:0] taps [N_TAPS];

  assign accept   = pix_valid_i && pix_ready_o;
  assign emit     = win_valid_o && win_ready_i;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign win_hit  = (row >= RW'(2)) && (col >= CW'(2));

  sobel_line_buf #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb0 (
    .clk   (clk_i_s),
    .we    (accept),
    .addr  (col),
    .wdata (pix_i),
    .rdata (lb0_q)
  );

  sobel_line_buf #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb1 (
    .clk   (clk_i_s),
    .we    (accept),
    .addr  (col),
    .wdata (lb0_q),
    .rdata (lb1_q)
  );

  always_ff @(posedge clk_i_s) begin
    if (rst_i_s) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = PRIME;
      PRIME:   if (accept && col_last && (row == RW'(1))) state_nx = STREAM;
      STREAM:  if (accept && col_last && row_last) state_nx = DRAIN;
      DRAIN:   if (emit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pix_ready_o  = 1'b0;
    frame_done_o = 1'b0;
    if (!rst_i_s) begin
      pix_ready_o  = (state != DRAIN) && (!win_valid_o || win_ready_i);
      frame_done_o = (state == DRAIN) && emit;
    end
  end

  always_ff @(posedge clk_i_s) begin
    if (rst_i_s || frame_done_o) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i_s) begin
    if (rst_i_s) begin
      col_a <= '{default: '0};
      col_b <= '{default: '0};
    end else if (accept) begin
      col_a <= col_b;
      col_b <= '{lb1_q, lb0_q, pix_i};
    end
  end

  always_ff @(posedge clk_i_s) begin
    if (rst_i_s) begin
      for (int k = 0; k < N_TAPS; k++) taps[k] <= '0;
      win_valid_o <= 1'b0;
    end else if (accept && win_hit) begin
      taps[TAP_TL] <= col_a[0];
      taps[TAP_TC] <= col_b[0];
      taps[TAP_TR] <= lb1_q;
      taps[TAP_ML] <= col_a[1];
      taps[TAP_MC] <= col_b[1];
      taps[TAP_MR] <= lb0_q;
      taps[TAP_BL] <= col_a[2];
      taps[TAP_BC] <= col_b[2];
      taps[TAP_BR] <= pix_i;
      win_valid_o  <= 1'b1;
    end else if (emit) begin
      win_valid_o <= 1'b0;
    end
  end

`ifdef SOBEL_WIN_COORD_EN
  always_ff @(posedge clk_i_s) begin
    if (rst_i_s) begin
      win_row_o <= '0;
      win_col_o <= '0;
    end else if (accept && win_hit) begin
      win_row_o <= row - 1'b1;
      win_col_o <= col - 1'b1;
    end
  end
`endif

  assign win_o_0 = taps[TAP_TL];
  assign win_o_1 = taps[TAP_TC];
  assign win_o_2 = taps[TAP_TR];
  assign win_o_3 = taps[TAP_ML];
  assign win_o_4 = taps[TAP_MC];
  assign win_o_5 = taps[TAP_MR];
  assign win_o_6 = taps[TAP_BL];
  assign win_o_7 = taps[TAP_BC];
  assign win_o_8 = taps[TAP_BR];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: a 4x4 and an 8x8 instance share stimulus, selected by sel;
// expected windows are queued on each accepted interior pixel and compared when emitted.
module tb_sobel_window_gen;

  typedef struct {
    logic [0:8][7:0] t;
    int              r;
    int              c;
    bit              last;
  } exp_t;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic [7:0] pix       = '0;
  logic       pix_valid = 1'b0;
  logic       wrdy      = 1'b1;
  int sel = 0;
  int total = 0;
  int bad = 0;
  int n_emit = 0;
  int n_done = 0;
  int rmode = 0;
  int stall_at = -1;
  int stall_left = 0;
  int acc_r = 0;
  int acc_c = 0;
  exp_t            exp_q[$];
  logic [0:8][7:0] wlog[$];
  int              clog[$];
  logic [7:0]      img [8][8];

  always #5 clk = ~clk;

  logic pv4, pv8, wr4, wr8, pr4, pr8, wv4, wv8, fd4, fd8;
  logic [7:0] w4 [9];
  logic [7:0] w8 [9];
  assign pv4 = pix_valid && (sel == 0);
  assign pv8 = pix_valid && (sel != 0);
  assign wr4 = wrdy && (sel == 0);
  assign wr8 = wrdy && (sel != 0);
`ifdef SOBEL_WIN_COORD_EN
  logic [1:0] r4, c4;
  logic [2:0] r8, c8;
`endif

  sobel_window_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) dut4 (
    .clk_i_s(clk), .rst_i_s(rst), .pix_i(pix), .pix_valid_i(pv4), .pix_ready_o(pr4),
    .win_o_0(w4[0]), .win_o_1(w4[1]), .win_o_2(w4[2]), .win_o_3(w4[3]), .win_o_4(w4[4]),
    .win_o_5(w4[5]), .win_o_6(w4[6]), .win_o_7(w4[7]), .win_o_8(w4[8]),
    .win_valid_o(wv4), .win_ready_i(wr4), .frame_done_o(fd4)
`ifdef SOBEL_WIN_COORD_EN
    , .win_row_o(r4), .win_col_o(c4)
`endif
  );

  sobel_window_gen #(.IMG_W(8), .IMG_H(8), .DATA_W(8)) dut8 (
    .clk_i_s(clk), .rst_i_s(rst), .pix_i(pix), .pix_valid_i(pv8), .pix_ready_o(pr8),
    .win_o_0(w8[0]), .win_o_1(w8[1]), .win_o_2(w8[2]), .win_o_3(w8[3]), .win_o_4(w8[4]),
    .win_o_5(w8[5]), .win_o_6(w8[6]), .win_o_7(w8[7]), .win_o_8(w8[8]),
    .win_valid_o(wv8), .win_ready_i(wr8), .frame_done_o(fd8)
`ifdef SOBEL_WIN_COORD_EN
    , .win_row_o(r8), .win_col_o(c8)
`endif
  );

  logic pix_ready_m, win_valid_m, frame_done_m;
  logic [0:8][7:0] taps_m;
  int row_m, col_m;
  always_comb begin
    pix_ready_m  = (sel == 0) ? pr4 : pr8;
    win_valid_m  = (sel == 0) ? wv4 : wv8;
    frame_done_m = (sel == 0) ? fd4 : fd8;
    for (int k = 0; k < 9; k++) taps_m[k] = (sel == 0) ? w4[k] : w8[k];
    row_m = 0;
    col_m = 0;
`ifdef SOBEL_WIN_COORD_EN
    row_m = (sel == 0) ? int'(r4) : int'(r8);
    col_m = (sel == 0) ? int'(c4) : int'(c8);
`endif
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Scoreboard: compare presented windows, then queue the window completed by this cycle's accept.
  always @(negedge clk) begin : mon
    exp_t e;
    logic emit, last_exp;
    int   w;
    w = (sel == 0) ? 4 : 8;
    if (rst) begin
      exp_q.delete();
      acc_r = 0;
      acc_c = 0;
    end else begin
      emit     = win_valid_m && wrdy;
      last_exp = 1'b0;
      if (win_valid_m) begin
        if (exp_q.size() == 0) begin
          checki("spurious_window", 1, 0);
        end else begin
          e = exp_q[0];
          check("taps", taps_m, e.t);
`ifdef SOBEL_WIN_COORD_EN
          checki("coord", row_m * 16 + col_m, e.r * 16 + e.c);
`endif
          if (!wrdy || e.last) checki("ready_blocked", int'(pix_ready_m), 0);
          last_exp = emit && e.last;
          if (emit) begin
            wlog.push_back(taps_m);
            clog.push_back(row_m * 16 + col_m);
            n_emit++;
            void'(exp_q.pop_front());
          end
        end
      end
      checki("frame_done", int'(frame_done_m), int'(last_exp));
      if (frame_done_m) n_done++;
      if (pix_valid && pix_ready_m) begin
        if (acc_r >= 2 && acc_c >= 2) begin
          for (int k = 0; k < 9; k++) e.t[k] = img[acc_r - 2 + k / 3][acc_c - 2 + k % 3];
          e.r    = acc_r - 1;
          e.c    = acc_c - 1;
          e.last = (acc_r == w - 1) && (acc_c == w - 1);
          exp_q.push_back(e);
        end
        acc_c++;
        if (acc_c == w) begin
          acc_c = 0;
          acc_r++;
          if (acc_r == w) acc_r = 0;
        end
      end
    end
  end

  // Consumer: always ready, random, or a 5-clock stall on one chosen window.
  always @(posedge clk) begin
    #1;
    if (rmode == 1) wrdy = 1'($urandom_range(0, 1));
    else if (rmode == 2 && win_valid_m && n_emit == stall_at && stall_left > 0) begin
      wrdy = 1'b0;
      stall_left--;
    end else wrdy = 1'b1;
  end

  task automatic put_pix(input logic [7:0] p, input bit rnd);
    int guard;
    if (rnd) while ($urandom_range(0, 2) == 0) begin
      pix_valid = 1'b0;
      @(posedge clk); #1;
    end
    pix = p;
    pix_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!pix_ready_m && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    checki("accept_timeout", int'(guard < 300), 1);
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit flat, input int n, input bit rnd);
    int w;
    w = (sel == 0) ? 4 : 8;
    for (int r = 0; r < w; r++)
      for (int c = 0; c < w; c++) img[r][c] = flat ? 8'hFF : 8'(base + r * w + c);
    for (int i = 0; i < n; i++) put_pix(img[i / w][i % w], rnd);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || win_valid_m) && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    checki("drain_timeout", int'(guard < 1000), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int be, bd;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checki("rst_ready4", int'(pr4), 0);
    checki("rst_valid4", int'(wv4), 0);
    checki("rst_done4", int'(fd4), 0);
    check("rst_taps4", {w4[0], w4[1], w4[2], w4[3], w4[4], w4[5], w4[6], w4[7], w4[8]}, 72'd0);
    checki("rst_ready8", int'(pr8), 0);
    checki("rst_valid8", int'(wv8), 0);
    check("rst_taps8", {w8[0], w8[1], w8[2], w8[3], w8[4], w8[5], w8[6], w8[7], w8[8]}, 72'd0);
`ifdef SOBEL_WIN_COORD_EN
    checki("rst_coord4", int'({r4, c4}), 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checki("idle_ready", int'(pix_ready_m), 1);
    @(posedge clk); #1;

    // 4x4 ramp, free-flowing
    be = n_emit; bd = n_done;
    send_frame(0, 1'b0, 16, 1'b0);
    wait_idle();
    checki("t1_windows", n_emit - be, 4);
    checki("t1_done", n_done - bd, 1);
    check("t1_first", wlog[be], {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10});
    check("t1_last", wlog[be + 3], {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15});
`ifdef SOBEL_WIN_COORD_EN
    checki("t1_coord0", clog[be], 16 * 1 + 1);
    checki("t1_coord1", clog[be + 1], 16 * 1 + 2);
    checki("t1_coord2", clog[be + 2], 16 * 2 + 1);
    checki("t1_coord3", clog[be + 3], 16 * 2 + 2);
`endif

    // same frame, consumer stalls 5 clocks on the second window
    be = n_emit; bd = n_done;
    stall_at = n_emit + 1; stall_left = 5; rmode = 2;
    send_frame(0, 1'b0, 16, 1'b0);
    wait_idle();
    rmode = 0;
    checki("t2_stall_applied", stall_left, 0);
    checki("t2_windows", n_emit - be, 4);
    checki("t2_done", n_done - bd, 1);
    check("t2_held", wlog[be + 1], {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11});

    // two 4x4 frames back-to-back
    be = n_emit; bd = n_done;
    send_frame(0, 1'b0, 16, 1'b0);
    send_frame(16, 1'b0, 16, 1'b0);
    wait_idle();
    checki("t3_windows", n_emit - be, 8);
    checki("t3_done", n_done - bd, 2);
    check("t3_f2_first", wlog[be + 4], {8'd16, 8'd17, 8'd18, 8'd20, 8'd21, 8'd22, 8'd24, 8'd25, 8'd26});

    // 8x8 flat frame with random valid and ready
    sel = 1;
    @(posedge clk); #1;
    be = n_emit; bd = n_done;
    rmode = 1;
    send_frame(0, 1'b1, 64, 1'b1);
    rmode = 0;
    wait_idle();
    checki("t4_windows", n_emit - be, 36);
    checki("t4_done", n_done - bd, 1);

    // reset after 20 pixels of an 8x8 ramp, then a full fresh frame
    send_frame(0, 1'b0, 20, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checki("t5_rst_ready", int'(pix_ready_m), 0);
    checki("t5_rst_done", int'(frame_done_m), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checki("t5_rst_valid", int'(win_valid_m), 0);
    check("t5_rst_taps", taps_m, 72'd0);
    @(posedge clk); #1;
    be = n_emit; bd = n_done;
    send_frame(3, 1'b0, 64, 1'b0);
    wait_idle();
    checki("t5_windows", n_emit - be, 36);
    checki("t5_done", n_done - bd, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
